// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM stage and a synchronous single-port data RAM.
// Handles byte/half/word accesses, sign/zero extension and read-modify-write sub-word stores.
module mem_access_unit #(
    parameter int unsigned len        = 32,
    parameter int unsigned RAM_ADDR_W = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [len-1:0]        i_address,
    input  logic [len-1:0]        i_write_data,
    output logic                  o_stall,
    output logic                  o_done,
    output logic                  o_misaligned,
    output logic [len-1:0]        o_read_data,
    output logic [RAM_ADDR_W-1:0] o_ram_addr,
    output logic [len-1:0]        o_ram_din,
    output logic                  o_ram_we,
    output logic                  o_ram_en,
    input  logic [len-1:0]        i_ram_dout
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_WAIT, WRITE, DONE} state_e;

    state_e                  state_q, state_d;
    logic [RAM_ADDR_W+1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic                    mis_q;
    logic [len-1:0]          wdata_q;
    logic [len-1:0]          merge_q;
    logic [len-1:0]          read_data_q;

    logic                    req_ok;
    logic                    in_mis;
    logic [4:0]              lane_sh;
    logic [len-1:0]          shifted;
    logic [len-1:0]          load_val;
    logic [len-1:0]          lane_mask;
    logic [len-1:0]          merged;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^i_address[len-1:RAM_ADDR_W+2];

    // Reset gates acceptance so no RAM strobe or stall escapes while i_rst is low.
    assign req_ok = i_rst && (state_q == IDLE) && i_valid && (i_mem_read ^ i_mem_write);
    assign in_mis = ((i_size == 2'b01) && i_address[0]) ||
                    (i_size[1] && (i_address[1:0] != 2'b00));

    // Lane datapath works from the registered request, never from live inputs.
    assign lane_sh = {addr_q[1:0], 3'b000};
    assign shifted = i_ram_dout >> lane_sh;

    always_comb begin
        load_val = i_ram_dout;
        unique case (size_q)
            2'b00:   load_val = {{(len-8){~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{(len-16){~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_val = i_ram_dout;
        endcase
    end

    always_comb begin
        if (size_q == 2'b00) begin
            lane_mask = {{(len-8){1'b0}}, 8'hFF} << lane_sh;
        end else begin
            lane_mask = {{(len-16){1'b0}}, 16'hFFFF} << lane_sh;
        end
        merged = (i_ram_dout & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (in_mis) begin
                        state_d = DONE;
                    end else if (i_mem_read) begin
                        state_d = RD_WAIT;
                    end else if (i_size[1]) begin
                        state_d = DONE;
                    end else begin
                        state_d = RMW_WAIT;
                    end
                end
            end
            RD_WAIT:  state_d = DONE;
            RMW_WAIT: state_d = WRITE;
            WRITE:    state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        o_stall      = 1'b0;
        o_done       = 1'b0;
        o_misaligned = 1'b0;
        o_ram_en     = 1'b0;
        o_ram_we     = 1'b0;
        o_ram_addr   = addr_q[RAM_ADDR_W+1:2];
        o_ram_din    = merge_q;
        unique case (state_q)
            IDLE: begin
                if (i_rst) begin
                    o_ram_addr = i_address[RAM_ADDR_W+1:2];
                    o_ram_din  = i_write_data;
                end
                if (req_ok) begin
                    o_stall = 1'b1;
                    if (!in_mis) begin
                        o_ram_en = 1'b1;
                        o_ram_we = i_mem_write && i_size[1];
                    end
                end
            end
            RD_WAIT, RMW_WAIT: o_stall = 1'b1;
            WRITE: begin
                o_stall  = 1'b1;
                o_ram_en = 1'b1;
                o_ram_we = 1'b1;
            end
            DONE: begin
                o_done       = 1'b1;
                o_misaligned = mis_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            mis_q       <= 1'b0;
            wdata_q     <= '0;
            merge_q     <= '0;
            read_data_q <= '0;
        end else begin
            if (req_ok) begin
                addr_q  <= i_address[RAM_ADDR_W+1:0];
                size_q  <= i_size;
                uns_q   <= i_unsigned;
                mis_q   <= in_mis;
                wdata_q <= i_write_data;
            end
            if (state_q == RD_WAIT) begin
                read_data_q <= load_val;
            end
            if (state_q == RMW_WAIT) begin
                merge_q <= merged;
            end
        end
    end

    assign o_read_data = read_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset-abort sequence and
// randomized requests checked against a byte-addressed memory model.
module tb_mem_access_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid, i_mem_read, i_mem_write, i_unsigned;
    logic [1:0]  i_size;
    logic [31:0] i_address, i_write_data;
    logic        o_stall, o_done, o_misaligned, o_ram_we, o_ram_en;
    logic [31:0] o_read_data, o_ram_din;
    logic [10:0] o_ram_addr;
    logic [31:0] i_ram_dout;

    logic [31:0] ram [2048];
    logic [7:0]  mem_b [8192];
    logic [31:0] rd_ref;
    int          we_count;
    int          n_total, n_pass;

    mem_access_unit #(.len(32), .RAM_ADDR_W(11)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_size(i_size), .i_unsigned(i_unsigned),
        .i_address(i_address), .i_write_data(i_write_data), .o_stall(o_stall),
        .o_done(o_done), .o_misaligned(o_misaligned), .o_read_data(o_read_data),
        .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .o_ram_we(o_ram_we),
        .o_ram_en(o_ram_en), .i_ram_dout(i_ram_dout)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_ram_en) begin
            if (o_ram_we) ram[o_ram_addr] <= o_ram_din;
            i_ram_dout <= ram[o_ram_addr];
        end
        if (o_ram_we) we_count <= we_count + 1;
    end

    typedef struct {
        logic        v, rd, wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, wd;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_mis;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: byte-addressed memory, latency and extension rules applied directly.
    task automatic model_req(input logic v, rd, wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, wd, output int lat, output logic mis,
                             output logic [31:0] rdv);
        int n, a;
        logic [31:0] val;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        a = int'(addr % 32'd8192);
        mis = 1'b0;
        lat = 0;
        if (v && (rd != wr)) begin
            if (a % n != 0) begin
                mis = 1'b1;
                lat = 1;
            end else if (rd) begin
                lat = 2;
                val = 0;
                for (int i = 0; i < n; i++) val = val | (32'(mem_b[a+i]) << (8*i));
                if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
                rd_ref = val;
            end else begin
                for (int i = 0; i < n; i++) mem_b[a+i] = wd[8*i +: 8];
                lat = (n == 4) ? 1 : 3;
            end
        end
        rdv = rd_ref;
    endtask

    task automatic run_req(input string name, input logic v, rd, wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, wd,
                           input int exp_lat, input logic exp_mis, input logic [31:0] exp_rd);
        logic en0, we0, mis_seen, acc_al, st;
        logic [10:0] ra0;
        int lat, stall_cnt, done_cnt, wc0;
        @(negedge i_clk);
        i_valid = v; i_mem_read = rd; i_mem_write = wr; i_size = sz; i_unsigned = uns;
        i_address = addr; i_write_data = wd;
        #1;
        en0 = o_ram_en; we0 = o_ram_we; ra0 = o_ram_addr;
        stall_cnt = int'(o_stall); wc0 = we_count;
        lat = 0; done_cnt = 0; mis_seen = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge i_clk);
            // Scramble request fields mid-transaction; they must be ignored.
            i_valid = 1'b0; i_mem_read = $urandom; i_mem_write = $urandom;
            i_size = 2'($urandom); i_unsigned = $urandom;
            i_address = $urandom; i_write_data = $urandom;
            #1;
            if (o_done) begin
                done_cnt++;
                if (lat == 0) begin lat = c; mis_seen = o_misaligned; end
            end
            if (o_stall) stall_cnt++;
        end
        acc_al = (exp_lat > 0) && !exp_mis;
        st = acc_al && wr;
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " done_count"}, 32'(done_cnt), (exp_lat > 0) ? 32'd1 : 32'd0);
        chk({name, " misaligned"}, 32'(mis_seen), 32'(exp_mis));
        chk({name, " read_data"}, o_read_data, exp_rd);
        chk({name, " stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        chk({name, " ram_en0"}, 32'(en0), 32'(acc_al));
        chk({name, " ram_we0"}, 32'(we0), 32'(st && sz[1]));
        chk({name, " we_pulses"}, 32'(we_count - wc0), 32'(st));
        if (acc_al) chk({name, " ram_addr0"}, 32'(ra0), (addr % 32'd8192) >> 2);
    endtask

    vec_t vecs [$];

    initial begin
        int lat;
        logic mis;
        logic [31:0] rdv, a, exp_w;
        logic v, rd, wr, uns;
        logic [1:0] sz;
        int r, wc0, bad;

        n_total = 0; n_pass = 0; we_count = 0; rd_ref = 0;
        for (int i = 0; i < 2048; i++) ram[i] = 0;
        for (int i = 0; i < 8192; i++) mem_b[i] = 0;
        i_ram_dout = 0;
        // Request held active during reset must not leak out.
        i_rst = 1'b0; i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
        i_size = 2'b10; i_unsigned = 1'b0; i_address = 32'h10; i_write_data = 0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("reset ctrl {done,mis,stall,en,we}",
            {27'd0, o_done, o_misaligned, o_stall, o_ram_en, o_ram_we}, 32'd0);
        chk("reset read_data", o_read_data, 32'd0);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;

        //            v     rd    wr    sz     uns   addr          wd            exp_rd        lat mis
        vecs.push_back('{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10,      32'hDEADBEEF, 32'h0,        1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13,      32'h0,        32'hFFFFFFDE, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13,      32'h0,        32'h000000DE, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h12,      32'h00001234, 32'h000000DE, 3, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10,      32'h0,        32'h1234BEEF, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h22,      32'h0,        32'h1234BEEF, 1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10,      32'h55555555, 32'h1234BEEF, 0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h2010,    32'h0,        32'h1234BEEF, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12,      32'h0,        32'h00001234, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11,      32'hFFFFFFAB, 32'h00001234, 3, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10,      32'h0,        32'h1234ABEF, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h10,      32'h0,        32'hFFFFABEF, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h11,      32'h0000BBBB, 32'hFFFFABEF, 1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10,      32'h0,        32'hFFFFABEF, 0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10,      32'h0,        32'hFFFFABEF, 0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 32'h12,      32'h0,        32'hFFFFABEF, 1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h2014,    32'hCAFEF00D, 32'hFFFFABEF, 1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14,      32'h0,        32'hCAFEF00D, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h17,      32'h0,        32'hFFFFFFCA, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h16,      32'h0,        32'h0000CAFE, 2, 1'b0});

        foreach (vecs[i]) begin
            model_req(vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns,
                      vecs[i].addr, vecs[i].wd, lat, mis, rdv);
            run_req($sformatf("vec%0d", i), vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].sz,
                    vecs[i].uns, vecs[i].addr, vecs[i].wd,
                    vecs[i].exp_lat, vecs[i].exp_mis, vecs[i].exp_rd);
        end

        // Reset pulsed while a byte store sits in RMW_WAIT: aborted, RAM untouched.
        @(negedge i_clk);
        wc0 = we_count;
        i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b1; i_size = 2'b00;
        i_unsigned = 1'b0; i_address = 32'h11; i_write_data = 32'h77;
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        chk("rmw_wait stall", 32'(o_stall), 32'd1);
        i_rst = 1'b0;
        #1;
        chk("abort ctrl {done,mis,stall,en,we}",
            {27'd0, o_done, o_misaligned, o_stall, o_ram_en, o_ram_we}, 32'd0);
        chk("abort read_data", o_read_data, 32'd0);
        chk("abort ram_din", o_ram_din, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        rd_ref = 0;
        repeat (4) @(negedge i_clk);
        chk("abort we_pulses", 32'(we_count - wc0), 32'd0);
        model_req(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, mis, rdv);
        run_req("abort reload", 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, mis, rdv);
        chk("abort reload value", o_read_data, 32'h1234ABEF);

        // Randomized requests against the model.
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 7);
            v = (r != 0);
            rd = (r <= 4) ? (r[0] == 1'b1) : (r == 6);
            wr = (r <= 4) ? (r[0] == 1'b0) : (r == 6);
            sz = 2'($urandom);
            uns = $urandom;
            a = $urandom_range(0, 127) | (32'($urandom_range(0, 7)) << 13);
            model_req(v, rd, wr, sz, uns, a, $urandom, lat, mis, rdv);
            // wd must match the model; reuse the bytes the model just wrote for stores.
            exp_w = {mem_b[(a % 8192) & ~32'd3 | 3], mem_b[(a % 8192) & ~32'd3 | 2],
                     mem_b[(a % 8192) & ~32'd3 | 1], mem_b[(a % 8192) & ~32'd3]};
            exp_w = exp_w >> (8 * (a % 4));
            run_req($sformatf("rand%0d", k), v, rd, wr, sz, uns, a, exp_w, lat, mis, rdv);
        end

        bad = 0;
        for (int w = 0; w < 2048; w++) begin
            if (ram[w] !== {mem_b[4*w+3], mem_b[4*w+2], mem_b[4*w+1], mem_b[4*w]}) bad++;
        end
        chk("ram_image mismatching words", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: len, 32, data/address width; RAM_ADDR_W, 11, word-address width for the 2048-word data RAM.
REQ-002 Ports SHALL be, clock and reset first:
i_clk  in  1  single clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_valid  in  1  EX/MEM request present
i_mem_read  in  1  load request
i_mem_write  in  1  store request
i_size  in  2  00 byte, 01 half, 10/11 word
i_unsigned  in  1  load zero-extends when 1, sign-extends when 0
i_address  in  len  byte address
i_write_data  in  len  store data, right-justified
o_stall  out  1  freeze upstream pipeline
o_done  out  1  one-cycle completion pulse
o_misaligned  out  1  one-cycle alignment-fault pulse, coincident with o_done
o_read_data  out  len  extended load result
o_ram_addr  out  RAM_ADDR_W  word address = i_address[RAM_ADDR_W+1:2]
o_ram_din  out  len  RAM write data
o_ram_we  out  1  RAM write enable
o_ram_en  out  1  RAM enable
i_ram_dout  in  len  RAM read data, valid one cycle after o_ram_en
REQ-003 Clock and reset SHALL be one clock i_clk, with i_rst asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, RD_WAIT, RMW_WAIT, WRITE, DONE.
REQ-005 A request SHALL be accepted in IDLE only when i_valid=1 and exactly one of i_mem_read/i_mem_write is 1; both set or neither set SHALL be a no-op (no RAM access, no o_done).
REQ-006 Alignment: half requires addr[0]=0; word requires addr[1:0]=00; a misaligned request SHALL do no RAM access and go IDLE->DONE with o_misaligned=1 in DONE.
REQ-007 Byte lanes SHALL be little-endian: offset 0 = bits [7:0], offset 3 = bits [31:24]; half offset 0 = [15:0], offset 2 = [31:16].
REQ-008 Load: IDLE (o_ram_en=1) -> RD_WAIT (capture i_ram_dout, extract lane, extend) -> DONE; o_read_data SHALL update at the RD_WAIT->DONE edge and otherwise hold.
REQ-009 Word store: IDLE (o_ram_en=1, o_ram_we=1, o_ram_din=i_write_data) -> DONE.
REQ-010 Sub-word store (read-modify-write): IDLE (o_ram_en=1, we=0) -> RMW_WAIT (merge store lane into captured i_ram_dout, keep other lanes) -> WRITE (en=1, we=1, din=merged word) -> DONE.
REQ-011 Address, size, unsigned and write data SHALL be registered at acceptance and used for the whole transaction; input changes mid-transaction SHALL have no effect.
REQ-012 o_stall SHALL be combinational: 1 in IDLE on acceptance (including misaligned) and in RD_WAIT, RMW_WAIT and WRITE; 0 in DONE and when idle.
REQ-013 o_done SHALL be 1 only in DONE; DONE SHALL always go to IDLE next cycle, and i_valid in DONE SHALL be ignored.
REQ-014 Latency, acceptance to o_done, SHALL be: word store 1 cycle, load 2, sub-word store 3, misaligned 1.
REQ-015 o_ram_we SHALL never be 1 outside IDLE-accepted word store or WRITE; o_ram_en/o_ram_we SHALL be 0 in RD_WAIT, RMW_WAIT and DONE.
REQ-016 Address bits above RAM_ADDR_W+1 SHALL be ignored, so addresses wrap modulo 8192 bytes.

Reset
REQ-017 While i_rst=0, state SHALL be IDLE and o_read_data, the merge register and all captured registers SHALL be 0; o_done, o_misaligned, o_stall, o_ram_en and o_ram_we SHALL be 0.
REQ-018 Reset asserted in RD_WAIT or RMW_WAIT SHALL abort the transaction with the RAM word unchanged. Reset in WRITE SHALL leave the RAM word either old or merged, never partially written.

Verification
REQ-019 Word store addr 0x10, data 0xDEADBEEF -> cycle 0: en=1, we=1, ram_addr=4; cycle 1: o_done=1, o_stall=0.
REQ-020 After REQ-019, byte load addr 0x13 with i_unsigned=0 -> o_read_data=0xFFFFFFDE after 2 cycles; with i_unsigned=1 -> 0x000000DE.
REQ-021 After REQ-019, half store addr 0x12, data 0x00001234 -> RAM read, then write 0x1234BEEF, o_done 3 cycles after acceptance; o_stall high for exactly 3 cycles.
REQ-022 Word load addr 0x22 -> o_misaligned=1 and o_done=1 in the next cycle; no o_ram_en; o_read_data unchanged.
REQ-023 Byte store addr 0x11, with i_rst pulsed low during RMW_WAIT -> all outputs 0, state IDLE, no we pulse; a later word load of addr 0x10 returns the prior value.
REQ-024 i_mem_read=i_mem_write=1 with i_valid=1 -> no stall, no RAM enable, no o_done; address 0x2010 word load -> ram_addr=4 (wrap).
